// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage
// Decode/issue stage sitting directly upstream of the ALU. It accepts one RV32
// R-type instruction at a time, reads rs1/rs2 from an internal register file,
// waits on read-after-write hazards using a per-register busy scoreboard, and
// presents the operands plus function fields to the execute side. ALU results
// come back through the writeback port.
//
// Optional feature: define ILLEGAL_TRAP_EN to add the opcode/func legality
// check and the one-cycle 'illegal' output pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (instr_ready decodes from state)
//   instr                    raw 32-bit instruction word
//   issue_valid/issue_ready  operand handshake towards the ALU
//   func3, func7, rd_addr    instruction fields of the issued instruction
//   rs1_data, rs2_data       source operand values
//   wb_valid, wb_addr,
//   wb_data                  register file writeback
//   illegal                  one-cycle illegal-instruction pulse (ILLEGAL_TRAP_EN only)
module rtype_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [2:0]            func3,
    output logic [6:0]            func7,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic                  wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

    state_t                state, state_nx;
    logic [31:0]           instr_p0;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic [AW-1:0]         rs1_a, rs2_a;
    logic                  rs1_blk, rs2_blk;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
    logic                  accept, go_issue, fire;
`ifdef ILLEGAL_TRAP_EN
    logic                  legal, go_illegal;
`else
    logic                  unused_opcode;
    assign unused_opcode = ^instr_p0[6:0];
`endif

    // Operand read with same-cycle writeback bypass; x0 always reads zero.
    always_comb begin
        rs1_a   = instr_p0[15 +: AW];
        rs2_a   = instr_p0[20 +: AW];
        rs1_blk = (rs1_a != '0) && busy[rs1_a] && !(wb_valid && wb_addr == rs1_a);
        rs2_blk = (rs2_a != '0) && busy[rs2_a] && !(wb_valid && wb_addr == rs2_a);
        if (rs1_a == '0)                         rs1_val = '0;
        else if (wb_valid && wb_addr == rs1_a)   rs1_val = wb_data;
        else                                     rs1_val = regs[rs1_a];
        if (rs2_a == '0)                         rs2_val = '0;
        else if (wb_valid && wb_addr == rs2_a)   rs2_val = wb_data;
        else                                     rs2_val = regs[rs2_a];
`ifdef ILLEGAL_TRAP_EN
        legal = 1'b0;
        if (instr_p0[6:0] == 7'b0110011) begin
            case ({instr_p0[31:25], instr_p0[14:12]})
                10'h000, 10'h100, 10'h004, 10'h006, 10'h007,
                10'h001, 10'h005, 10'h105, 10'h002, 10'h003: legal = 1'b1;
                default:                                     legal = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        go_issue = 1'b0;
        fire     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        go_illegal = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept   = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                // Hazard resolution comes first; legality is only judged once sources are free.
                if (!rs1_blk && !rs2_blk) begin
`ifdef ILLEGAL_TRAP_EN
                    if (legal) begin
                        go_issue = 1'b1;
                        state_nx = ISSUE;
                    end else begin
                        go_illegal = 1'b1;
                        state_nx   = IDLE;
                    end
`else
                    go_issue = 1'b1;
                    state_nx = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (issue_ready) begin
                    fire     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);

    // Stage p0 -> issue outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p0    <= '0;
            issue_valid <= 1'b0;
            func3       <= '0;
            func7       <= '0;
            rs1_data    <= '0;
            rs2_data    <= '0;
            rd_addr     <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            if (accept) instr_p0 <= instr;
            if (go_issue) begin
                issue_valid <= 1'b1;
                func3       <= instr_p0[14:12];
                func7       <= instr_p0[31:25];
                rd_addr     <= instr_p0[7 +: AW];
                rs1_data    <= rs1_val;
                rs2_data    <= rs2_val;
            end else if (fire) begin
                issue_valid <= 1'b0;
            end
`ifdef ILLEGAL_TRAP_EN
            illegal <= go_illegal;
`endif
        end
    end

    // Register file and scoreboard; the issue-time set is written last so it
    // wins over a same-cycle writeback clear of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wb_valid && wb_addr != '0) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            if (fire && rd_addr != '0) busy[rd_addr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rtype_issue_stage.sv
module tb_rtype_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    rtype_issue_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .func3(func3), .func7(func7), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_addr(rd_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    int total  = 0;
    int passed = 0;

    // Reference model: architectural register values and pending-result flags.
    logic [31:0] mregs [32];
    bit          mbusy [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mregs[a];
    endfunction

    function automatic bit mblk(input logic [4:0] a);
        return (a != 5'd0) && mbusy[a];
    endfunction

    task automatic model_wb(input logic [4:0] a, input logic [31:0] d);
        if (a != 5'd0) begin
            mregs[a] = d;
            mbusy[a] = 1'b0;
        end
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_valid = 1'b0;
        model_wb(a, d);
    endtask

    task automatic accept(input logic [31:0] ins);
        instr_valid = 1'b1; instr = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic consume(input logic [4:0] d);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        if (d != 5'd0) mbusy[d] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        total++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got=%0h exp=0", issue_valid); else passed++;
        total++; if (instr_ready !== 1'b1) $display("FAIL reset_instr_ready got=%0h exp=1", instr_ready); else passed++;
        total++; if ({func7, func3, rs1_data, rs2_data, rd_addr} !== '0)
            $display("FAIL reset_outputs got=%0h/%0h/%0h/%0h/%0h exp=0", func7, func3, rs1_data, rs2_data, rd_addr); else passed++;
`ifdef ILLEGAL_TRAP_EN
        total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%0h exp=0", illegal); else passed++;
`endif
    endtask

    task automatic test_add_zero();
        accept(32'h002081B3);
        total++; if ({issue_valid, instr_ready} !== 2'b00) $display("FAIL t1_check_state got=%b exp=00", {issue_valid, instr_ready}); else passed++;
        tick();
        total++; if (issue_valid !== 1'b1) $display("FAIL t1_issue_valid got=%0h exp=1", issue_valid); else passed++;
        total++; if ({func7, func3, rs1_data, rs2_data, rd_addr} !== {7'd0, 3'd0, 32'd0, 32'd0, 5'd3})
            $display("FAIL t1_fields got=%0h/%0h/%0h/%0h/%0h exp=0/0/0/0/3", func7, func3, rs1_data, rs2_data, rd_addr); else passed++;
        consume(5'd3);
        total++; if ({issue_valid, instr_ready} !== 2'b01) $display("FAIL t1_back_idle got=%b exp=01", {issue_valid, instr_ready}); else passed++;
    endtask

    task automatic test_wb_operands();
        drive_wb(5'd1, 32'h10);
        drive_wb(5'd2, 32'h20);
        accept(32'h002081B3);
        tick();
        total++; if ({issue_valid, rs1_data, rs2_data} !== {1'b1, mread(5'd1), mread(5'd2)})
            $display("FAIL t2_operands got=%0h/%0h/%0h exp=1/10/20", issue_valid, rs1_data, rs2_data); else passed++;
        consume(5'd3);
    endtask

    task automatic test_raw_stall();
        accept(32'h40118233);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if ({issue_valid, instr_ready} !== 2'b00)
                $display("FAIL t3_stall got=%b exp=00", {issue_valid, instr_ready}); else passed++;
        end
        drive_wb(5'd3, 32'h30);
        total++; if ({issue_valid, func7, rs1_data, rs2_data, rd_addr} !== {1'b1, 7'h20, 32'h30, 32'h10, 5'd4})
            $display("FAIL t3_release got=%0h/%0h/%0h/%0h/%0h exp=1/20/30/10/4", issue_valid, func7, rs1_data, rs2_data, rd_addr); else passed++;
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive_wb(5'd1, 32'h55);
            else tick();
            total++; if ({issue_valid, instr_ready, rs1_data, rs2_data, func7} !== {1'b1, 1'b0, 32'h30, 32'h10, 7'h20})
                $display("FAIL t4_hold got=%0h/%0h/%0h/%0h/%0h exp=1/0/30/10/20", issue_valid, instr_ready, rs1_data, rs2_data, func7); else passed++;
        end
        consume(5'd4);
        total++; if ({issue_valid, instr_ready} !== 2'b01) $display("FAIL t4_release got=%b exp=01", {issue_valid, instr_ready}); else passed++;
    endtask

    task automatic test_x0();
        drive_wb(5'd0, 32'hFFFF_FFFF);
        accept(32'h00100033);
        tick();
        total++; if ({issue_valid, rs1_data, rs2_data, rd_addr} !== {1'b1, 32'd0, 32'h55, 5'd0})
            $display("FAIL t5_x0_read got=%0h/%0h/%0h/%0h exp=1/0/55/0", issue_valid, rs1_data, rs2_data, rd_addr); else passed++;
        consume(5'd0);
        accept(32'h000002B3);
        tick();
        total++; if ({issue_valid, rs1_data, rs2_data, rd_addr} !== {1'b1, 32'd0, 32'd0, 5'd5})
            $display("FAIL t5_x0_nostall got=%0h/%0h/%0h/%0h exp=1/0/0/5", issue_valid, rs1_data, rs2_data, rd_addr); else passed++;
        consume(5'd5);
    endtask

    task automatic test_addi();
        accept(32'h00000013);
        tick();
`ifdef ILLEGAL_TRAP_EN
        total++; if ({illegal, issue_valid, instr_ready} !== 3'b101)
            $display("FAIL t6_illegal_pulse got=%b exp=101", {illegal, issue_valid, instr_ready}); else passed++;
        tick();
        total++; if ({illegal, issue_valid} !== 2'b00) $display("FAIL t6_illegal_end got=%b exp=00", {illegal, issue_valid}); else passed++;
`else
        total++; if ({issue_valid, func7, func3, rd_addr} !== {1'b1, 7'd0, 3'd0, 5'd0})
            $display("FAIL t6_addi_issue got=%0h/%0h/%0h/%0h exp=1/0/0/0", issue_valid, func7, func3, rd_addr); else passed++;
        consume(5'd0);
`endif
    endtask

    task automatic test_mid_reset();
        logic [31:0] ins;
        ins = (32'd7 << 20) | (32'd7 << 15) | (32'd8 << 7) | 32'h33;
        drive_wb(5'd7, 32'h77);
        accept(ins);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        total++; if ({issue_valid, instr_ready} !== 2'b01) $display("FAIL mid_reset_state got=%b exp=01", {issue_valid, instr_ready}); else passed++;
        tick(); tick();
        total++; if (issue_valid !== 1'b0) $display("FAIL mid_reset_dropped got=%0h exp=0", issue_valid); else passed++;
        accept(ins);
        tick();
        total++; if ({issue_valid, rs1_data, rs2_data} !== {1'b1, mread(5'd7), mread(5'd7)})
            $display("FAIL mid_reset_regs got=%0h/%0h/%0h exp=1/0/0", issue_valid, rs1_data, rs2_data); else passed++;
        consume(5'd8);
    endtask

    task automatic test_random();
        logic [9:0] ftab [10];
        ftab = '{10'h000, 10'h100, 10'h004, 10'h006, 10'h007, 10'h001, 10'h005, 10'h105, 10'h002, 10'h003};
        for (int t = 0; t < 60; t++) begin
            logic [9:0]  f;
            logic [4:0]  s1, s2, d, a;
            logic [31:0] ins, dat, e1, e2;
            bit          waited;
            int          nwb;
            nwb = $urandom_range(0, 2);
            for (int w = 0; w < nwb; w++) drive_wb(5'($urandom_range(0, 31)), $urandom);
            f  = ftab[$urandom_range(0, 9)];
            s1 = 5'($urandom_range(0, 31));
            s2 = 5'($urandom_range(0, 31));
            d  = 5'($urandom_range(0, 31));
            ins = {f[9:3], s2, s1, f[2:0], d, 7'h33};
            accept(ins);
            waited = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!(mblk(s1) || mblk(s2))) break;
                total++; if (issue_valid !== 1'b0) $display("FAIL rnd_stall t=%0d got=%0h exp=0", t, issue_valid); else passed++;
                a = mblk(s1) ? s1 : s2;
                drive_wb(a, $urandom);
                waited = 1'b1;
            end
            if (!waited) tick();
            e1 = mread(s1);
            e2 = mread(s2);
            total++; if ({issue_valid, func7, func3, rs1_data, rs2_data, rd_addr} !== {1'b1, f[9:3], f[2:0], e1, e2, d})
                $display("FAIL rnd_issue t=%0d got=%0h/%0h/%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h/%0h/%0h",
                         t, issue_valid, func7, func3, rs1_data, rs2_data, rd_addr, f[9:3], f[2:0], e1, e2, d); else passed++;
            nwb = $urandom_range(0, 2);
            for (int w = 0; w < nwb; w++) drive_wb(5'($urandom_range(0, 31)), $urandom);
            total++; if ({rs1_data, rs2_data} !== {e1, e2})
                $display("FAIL rnd_hold t=%0d got=%0h/%0h exp=%0h/%0h", t, rs1_data, rs2_data, e1, e2); else passed++;
            if ($urandom_range(0, 1) == 1) begin
                dat = $urandom;
                wb_valid = 1'b1; wb_addr = d; wb_data = dat;
                issue_ready = 1'b1;
                tick();
                wb_valid = 1'b0; issue_ready = 1'b0;
                model_wb(d, dat);
                if (d != 5'd0) mbusy[d] = 1'b1;
            end else begin
                consume(d);
            end
            total++; if ({issue_valid, instr_ready} !== 2'b01) $display("FAIL rnd_done t=%0d got=%b exp=01", t, {issue_valid, instr_ready}); else passed++;
        end
    endtask

    initial begin
        rst = 1'b0; instr_valid = 1'b0; instr = '0; issue_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        model_reset();
        test_reset();
        test_add_zero();
        test_wb_operands();
        test_raw_stall();
        test_hold();
        test_x0();
        test_addi();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
